// File: rtl/down_timer.sv
// Programmable down-counting timer: load, hold, one-shot/periodic
// modes, registered terminal-count and load-error pulses.
module down_timer #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic            stop,
  input  logic            en,
  input  logic            mode,
  input  logic [Size-1:0] D,
  output logic [Size-1:0] Q,
  output logic            busy,
  output logic            done,
  output logic            tc,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [Size-1:0] q, q_n;
  logic [Size-1:0] r, r_n;
  logic            mode_r, mode_n;
  logic            tc_n, err_n;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state  <= IDLE;
      q      <= '0;
      r      <= '0;
      mode_r <= 1'b0;
      tc     <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      r      <= r_n;
      mode_r <= mode_n;
      tc     <= tc_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    r_n     = r;
    mode_n  = mode_r;
    tc_n    = 1'b0;
    err_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      q_n     = '0;
    end else if (start) begin
      // a zero period is rejected and freezes everything for the cycle
      if (D != '0) begin
        state_n = RUN;
        q_n     = D;
        r_n     = D;
        mode_n  = mode;
      end else begin
        err_n = 1'b1;
      end
    end else if (state == RUN && en) begin
      if (q > 1) begin
        q_n = q - 1'b1;
      end else begin
        tc_n = 1'b1;
        if (mode_r) begin
          q_n = r;
        end else begin
          q_n     = '0;
          state_n = DONE;
        end
      end
    end
  end

  assign Q    = q;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: elapsed-tick model plus
// directed scenarios with hand-computed expectations.
module tb_down_timer;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic       stop;
  logic       en;
  logic       mode;
  logic [7:0] D;
  logic [7:0] Q;
  logic       busy;
  logic       done;
  logic       tc;
  logic       err;

  int checks = 0;
  int failures = 0;

  down_timer #(.Size(8)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
    .en(en), .mode(mode), .D(D), .Q(Q), .busy(busy),
    .done(done), .tc(tc), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: period, mode and enabled ticks elapsed since load
  bit m_run, m_done, m_mode, m_tc, m_err;
  int m_per, m_n;
  bit live = 0;

  always @(posedge clk) begin
    m_tc  = 0;
    m_err = 0;
    if (!clr_n) begin
      m_run = 0; m_done = 0; m_per = 0; m_mode = 0; m_n = 0;
    end else if (stop) begin
      m_run = 0; m_done = 0;
    end else if (start) begin
      if (D != 0) begin
        m_run = 1; m_done = 0; m_per = D; m_mode = mode; m_n = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_run && en) begin
      m_n++;
      if (m_n % m_per == 0) begin
        m_tc = 1;
        if (!m_mode) begin
          m_run = 0; m_done = 1;
        end
      end
    end
  end

  function automatic int exp_q();
    return m_run ? (m_per - (m_n % m_per)) : 0;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("m_q", int'(Q), exp_q());
      chk("m_busy", int'(busy), int'(m_run));
      chk("m_done", int'(done), int'(m_done));
      chk("m_tc", int'(tc), int'(m_tc));
      chk("m_err", int'(err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic s, input logic sp,
                     input logic e, input logic m,
                     input logic [7:0] d);
    start = s; stop = sp; en = e; mode = m; D = d;
  endtask

  int tcs[$];
  int n;
  bit seen;

  initial begin
    clr_n = 0;
    drv(0, 0, 0, 0, 8'd0);
    tick();
    live = 1;
    tick();
    chk("rst_q", Q, 0);
    chk("rst_busy", busy, 0);
    clr_n = 1;

    // one-shot D=4
    drv(1, 0, 1, 0, 8'd4);
    tick();
    chk("os_q4", Q, 4);
    chk("os_busy", busy, 1);
    start = 0;
    tick(); chk("os_q3", Q, 3);
    tick(); chk("os_q2", Q, 2);
    tick(); chk("os_q1", Q, 1);
    tick();
    chk("os_q0", Q, 0);
    chk("os_tc", tc, 1);
    chk("os_done", done, 1);
    chk("os_busy0", busy, 0);
    tick();
    chk("os_tc_off", tc, 0);
    chk("os_hold0", Q, 0);

    // periodic D=3 with a two-cycle hold
    drv(1, 0, 1, 1, 8'd3);
    tick();
    start = 0;
    for (int i = 1; i <= 11; i++) begin
      en = (i == 4 || i == 5) ? 1'b0 : 1'b1;
      tick();
      if (tc) begin
        tcs.push_back(i);
        chk("per_q_at_tc", Q, 3);
      end
    end
    chk("per_ntc", tcs.size(), 3);
    if (tcs.size() == 3) begin
      chk("per_t1", tcs[0], 3);
      chk("per_gap_hold", tcs[1] - tcs[0], 5);
      chk("per_gap", tcs[2] - tcs[1], 3);
    end

    // restart and stop
    drv(1, 0, 1, 0, 8'd10);
    tick();
    start = 0;
    repeat (4) tick();
    chk("rs_q6", Q, 6);
    drv(1, 0, 1, 0, 8'd2);
    tick();
    chk("rs_q2", Q, 2);
    start = 0;
    tick(); chk("rs_tc_early", tc, 0);
    tick(); chk("rs_tc", tc, 1);
    drv(1, 0, 1, 0, 8'd7);
    tick();
    start = 0;
    tick(); tick();
    chk("st_q5", Q, 5);
    stop = 1;
    tick();
    stop = 0;
    chk("st_q0", Q, 0);
    chk("st_busy", busy, 0);
    chk("st_tc", tc, 0);

    // rejected loads: idle, then mid-run
    drv(1, 0, 1, 0, 8'd0);
    tick();
    chk("rj_err", err, 1);
    chk("rj_busy", busy, 0);
    start = 0;
    tick();
    chk("rj_err_off", err, 0);
    drv(1, 0, 1, 0, 8'd5);
    tick();
    start = 0;
    tick();
    drv(1, 0, 1, 0, 8'd0);
    tick();
    chk("rj_run_q", Q, 4);
    chk("rj_run_err", err, 1);
    start = 0;
    tick();
    chk("rj_run_cont", Q, 3);

    // D=255 one-shot, bounded wait for tc
    drv(1, 0, 1, 0, 8'd255);
    tick();
    chk("max_q", Q, 255);
    start = 0;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      tick();
      n++;
      if (tc) seen = 1;
    end
    chk("max_cycles", seen ? n : -1, 255);

    // start and stop together while running
    drv(1, 0, 1, 0, 8'd6);
    tick();
    drv(1, 1, 1, 0, 8'd9);
    tick();
    chk("ss_q", Q, 0);
    chk("ss_busy", busy, 0);

    // start collides with terminal count
    drv(1, 0, 1, 0, 8'd2);
    tick();
    start = 0;
    tick();
    chk("col_q1", Q, 1);
    drv(1, 0, 1, 0, 8'd6);
    tick();
    chk("col_q", Q, 6);
    chk("col_tc", tc, 0);
    chk("col_busy", busy, 1);
    start = 0;
    repeat (6) tick();
    chk("col_done", done, 1);
    drv(1, 0, 1, 0, 8'd3);
    tick();
    chk("dn_done", done, 0);
    chk("dn_q", Q, 3);
    start = 0;

    // reset mid-count, glitch between edges ignored
    drv(1, 0, 1, 0, 8'd9);
    tick();
    start = 0;
    repeat (4) tick();
    chk("rm_q5", Q, 5);
    clr_n = 0;
    #2 clr_n = 1;
    tick();
    chk("rm_glitch", Q, 4);
    clr_n = 0;
    tick(); tick();
    chk("rm_q0", Q, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_tc", tc, 0);
    chk("rm_err", err, 0);
    clr_n = 1;
    #1;
    chk("rm_rel_q", Q, 0);
    chk("rm_rel_busy", busy, 0);
    tick();
    chk("rm_after", busy, 0);

    live = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer with parallel load, hold, one-shot/periodic modes and a terminal-count pulse. It is the count-down counterpart of the team's up-counter. It sits beside it in the integration datapath and provides delays, timeouts and periodic ticks to control FSMs. A small FSM (IDLE/RUN/DONE) wraps a Size-bit decrementer and a reload register.

## Interface
- Size, 8, width of load value, count and reload register
- clk  input  1  clock; all state changes on rising edge
- clr_n  input  1  reset, synchronous, active-low (sampled only on rising clk edge)
- start  input  1  load D and begin counting (level sampled each edge)
- stop  input  1  abort: return to IDLE, clear count
- en  input  1  count enable; low in RUN holds count
- mode  input  1  0 = one-shot, 1 = periodic; sampled only when start is accepted
- D  input  Size  load/period value; must be non-zero
- Q  output  Size  current count (registered)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE (one-shot expired)
- tc  output  1  terminal-count pulse, one cycle, registered
- err  output  1  one-cycle pulse: start rejected because D == 0

## Operation
- Reset (clr_n low at an edge): state IDLE; Q=0, R=0, mode_r=0, busy=0, done=0, tc=0, err=0. Applies in any state, including mid-count.
- Per-edge priority: clr_n > stop > start > countdown.
- stop (any state): IDLE, Q=0, busy=0, done=0. start is ignored in the same cycle.
- Accepted start means start=1, stop=0, D≠0, in any state. It does: Q<=D, R<=D, mode_r<=mode, state RUN. A start in RUN restarts the count. A start in DONE clears done.
- Rejected start means start=1 with D=0. It does: err=1 for one cycle. State, Q, R and mode_r are unchanged.
- Behaviour in RUN without start or stop:
  - en=0: Q holds, busy stays 1.
  - en=1, Q>1: Q<=Q-1.
  - en=1, Q=1, mode_r=0: Q<=0, state DONE, tc=1.
  - en=1, Q=1, mode_r=1: Q<=R, stay RUN, tc=1.
- DONE: Q holds 0, done=1, en ignored. Exits only via start, stop or reset.
- IDLE: Q holds its value, en ignored.
- Arithmetic: the decrement is modulo 2^Size, but Q never decrements below 1 in RUN, so there is no wrap. D=2^Size-1 is a legal maximum.
- tc and err are registered and default to 0 every cycle unless set as above. A start accepted in the same edge as a terminal transition wins: tc=0, Q=D.

## Timing
- Start accepted at edge k: after edge k, Q=D and busy=1.
- With en held high, after edge k+n: Q=D-n for n<D.
- One-shot, en high: after edge k+D, Q=0, done=1, busy=0, tc=1 for exactly that cycle.
- Periodic, en high: tc is high after edges k+D, k+2D, k+3D, and so on, which gives period D cycles. Q reads D in each tc cycle.
- Each cycle with en=0 in RUN delays expiry by exactly one cycle.
- busy, done and Q change only on clock edges; no combinational path from any input to any output.
- Reset is synchronous: clr_n low between edges has no effect until the next rising edge.

## Test plan
- Reset: hold clr_n=0 for 2 edges mid-count (Q=5) -> after the edge Q=0, busy=0, done=0, tc=0, err=0, state IDLE. Releasing clr_n between edges changes nothing until the next edge.
- One-shot: Size=8, D=4, mode=0, start pulse at edge k, en=1 -> Q=4,3,2,1 after edges k..k+3. After edge k+4: Q=0, tc=1 (one cycle), done=1, busy=0. Q then stays 0.
- Periodic with hold: D=3, mode=1, en dropped low for 2 cycles during count -> tc pulses spaced 3 cycles apart, except the interval containing the hold, which is 5 cycles. Q reads 3 on every tc cycle.
- Restart and stop: D=10 running at Q=6, start with D=2 -> Q=2, tc 2 cycles later. Then start D=7 followed by stop at Q=5 -> Q=0, IDLE, no tc.
- Rejected load and boundary: start with D=0 in IDLE -> err=1 for one cycle, Q and busy unchanged. D=255 one-shot -> tc exactly 255 cycles after start, no wrap of Q.
- Collisions:
  - start and stop in the same cycle -> IDLE, Q=0.
  - start at Q=1 with en=1 -> Q=D, tc=0, state RUN.
  - start in DONE -> done=0, RUN with the new D.
